// File: rtl/wb_intc.sv
// Wishbone B3 interrupt controller with synchroniser, per-line polarity, edge/level mode and W1C pending.
// Define WB_INTC_VECTOR_EN to map the read-only VECTOR register at offset 0x18.
module wb_intc #(
  parameter int NUM_IRQ = 32
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_IRQ-1:0] cpu_irq_o,
  output logic               irq_o
);

  localparam logic [2:0] OFF_PENDING  = 3'd0;
  localparam logic [2:0] OFF_ENABLE   = 3'd1;
  localparam logic [2:0] OFF_MODE     = 3'd2;
  localparam logic [2:0] OFF_POLARITY = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_SET      = 3'd5;
  localparam logic [2:0] OFF_VECTOR   = 3'd6;

  logic [NUM_IRQ-1:0] sync1_reg, sync2_reg, prev_reg;
  logic [NUM_IRQ-1:0] pending_reg, enable_reg, mode_reg, polarity_reg;
  logic [NUM_IRQ-1:0] pending_next, enable_next, mode_next, polarity_next;
  logic [NUM_IRQ-1:0] act, rise, wmask, wdata, set_bits, clr_bits, status;
  logic [31:0]        byte_mask, rdata_next;
  logic [2:0]         offset;
  logic               access, mapped, wr;
  logic               unused;

  assign unused   = ^{wb_adr_i[1:0], wb_dat_i, byte_mask};
  assign wb_rty_o = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_mask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
    end
  endgenerate

  assign wmask  = byte_mask[NUM_IRQ-1:0];
  assign wdata  = wb_dat_i[NUM_IRQ-1:0] & wmask;
  assign offset = wb_adr_i[4:2];
  assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

  always_comb begin
    mapped = (offset <= OFF_SET);
`ifdef WB_INTC_VECTOR_EN
    if (offset == OFF_VECTOR) mapped = 1'b1;
`endif
  end

  assign wr     = access & mapped & wb_we_i;
  assign act    = sync2_reg ^ polarity_reg;
  assign rise   = act & ~prev_reg;
  assign status = pending_reg & enable_reg;

  assign set_bits = (wr && offset == OFF_SET)     ? wdata : '0;
  assign clr_bits = (wr && offset == OFF_PENDING) ? wdata : '0;

  // Level lines mirror the request; edge lines latch, with set taking priority over W1C.
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
      assign pending_next[gi] = mode_reg[gi]
                              ? (set_bits[gi] | rise[gi] | (pending_reg[gi] & ~clr_bits[gi]))
                              : act[gi];
    end
  endgenerate

  assign enable_next   = (wr && offset == OFF_ENABLE)   ? ((enable_reg & ~wmask) | wdata)   : enable_reg;
  assign mode_next     = (wr && offset == OFF_MODE)     ? ((mode_reg & ~wmask) | wdata)     : mode_reg;
  assign polarity_next = (wr && offset == OFF_POLARITY) ? ((polarity_reg & ~wmask) | wdata) : polarity_reg;

`ifdef WB_INTC_VECTOR_EN
  logic [31:0] vector_reg, vector_next;

  always_comb begin
    vector_next = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (status[i]) vector_next = {1'b1, 26'd0, 5'(i)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) vector_reg <= '0;
    else         vector_reg <= vector_next;
  end
`endif

  always_comb begin
    rdata_next = '0;
    if (access && mapped && !wb_we_i) begin
      case (offset)
        OFF_PENDING:  rdata_next = 32'(pending_reg);
        OFF_ENABLE:   rdata_next = 32'(enable_reg);
        OFF_MODE:     rdata_next = 32'(mode_reg);
        OFF_POLARITY: rdata_next = 32'(polarity_reg);
        OFF_STATUS:   rdata_next = 32'(status);
`ifdef WB_INTC_VECTOR_EN
        OFF_VECTOR:   rdata_next = vector_reg;
`endif
        default:      rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      prev_reg     <= '0;
      pending_reg  <= '0;
      enable_reg   <= '0;
      mode_reg     <= '0;
      polarity_reg <= '0;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      wb_dat_o     <= '0;
      cpu_irq_o    <= '0;
      irq_o        <= 1'b0;
    end else begin
      sync1_reg    <= irq_i;
      sync2_reg    <= sync1_reg;
      prev_reg     <= act;
      pending_reg  <= pending_next;
      enable_reg   <= enable_next;
      mode_reg     <= mode_next;
      polarity_reg <= polarity_next;
      wb_ack_o     <= access & mapped;
      wb_err_o     <= access & ~mapped;
      wb_dat_o     <= rdata_next;
      cpu_irq_o    <= status;
      irq_o        <= |status;
    end
  end

endmodule

// File: tb/tb_wb_intc.sv
// Self-checking bench for wb_intc: directed scenarios plus randomized bus/IRQ traffic against a cycle model.
// Build with +define+WB_INTC_VECTOR_EN to exercise the VECTOR register.
module tb_wb_intc;

  localparam int NUM_IRQ = 32;
`ifdef WB_INTC_VECTOR_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif
  localparam logic [4:0] A_PEND = 5'h00, A_EN = 5'h04, A_MODE = 5'h08, A_POL = 5'h0C;
  localparam logic [4:0] A_STAT = 5'h10, A_SET = 5'h14, A_VEC = 5'h18, A_BAD = 5'h1C;

  logic               clk_i = 1'b0;
  logic               nrst_i = 1'b0;
  logic [4:0]         wb_adr_i = '0;
  logic [31:0]        wb_dat_i = '0;
  logic [3:0]         wb_sel_i = '0;
  logic               wb_we_i = 1'b0;
  logic               wb_cyc_i = 1'b0;
  logic               wb_stb_i = 1'b0;
  logic [31:0]        wb_dat_o;
  logic               wb_ack_o, wb_err_o, wb_rty_o;
  logic [NUM_IRQ-1:0] irq_i = '0;
  logic [NUM_IRQ-1:0] cpu_irq_o;
  logic               irq_o;

  int n_cmp = 0;
  int n_fail = 0;

  wb_intc #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .irq_i(irq_i), .cpu_irq_o(cpu_irq_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: requests become visible two edges after sampling; registers follow the register map.
  logic [31:0] m_h1, m_h2, m_prev, m_pend, m_en, m_mode, m_pol, m_dat, m_cpu, m_vec;
  logic        m_ack, m_err, m_irq;
  logic [31:0] c_act, c_stat, c_wm, c_wval, c_pend, c_rd, c_vec;
  logic [2:0]  c_off;
  logic        c_acc, c_mapped, c_wr, c_found;

  always_comb begin
    c_act    = m_h2 ^ m_pol;
    c_stat   = m_pend & m_en;
    c_acc    = wb_cyc_i & wb_stb_i & ~m_ack & ~m_err;
    c_off    = wb_adr_i[4:2];
    c_mapped = (c_off <= 3'd5) || (VEC_EN && c_off == 3'd6);
    c_wm     = '0;
    for (int b = 0; b < 4; b++) if (wb_sel_i[b]) c_wm[8*b +: 8] = 8'hFF;
    c_wval   = wb_dat_i & c_wm;
    c_wr     = c_acc & c_mapped & wb_we_i;
    c_pend   = '0;
    for (int i = 0; i < 32; i++) begin
      if (!m_mode[i])                              c_pend[i] = c_act[i];
      else if (c_wr && c_off == 3'd5 && c_wval[i]) c_pend[i] = 1'b1;
      else if (c_act[i] && !m_prev[i])             c_pend[i] = 1'b1;
      else if (c_wr && c_off == 3'd0 && c_wval[i]) c_pend[i] = 1'b0;
      else                                         c_pend[i] = m_pend[i];
    end
    c_vec   = '0;
    c_found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!c_found && c_stat[i]) begin
        c_vec   = 32'h8000_0000 | 32'(i);
        c_found = 1'b1;
      end
    end
    c_rd = '0;
    if (c_acc && c_mapped && !wb_we_i) begin
      case (c_off)
        3'd0:    c_rd = m_pend;
        3'd1:    c_rd = m_en;
        3'd2:    c_rd = m_mode;
        3'd3:    c_rd = m_pol;
        3'd4:    c_rd = c_stat;
        3'd6:    c_rd = m_vec;
        default: c_rd = '0;
      endcase
    end
  end

  always @(posedge clk_i) begin
    if (!nrst_i) begin
      m_h1 <= '0; m_h2 <= '0; m_prev <= '0; m_pend <= '0; m_en <= '0; m_mode <= '0;
      m_pol <= '0; m_dat <= '0; m_cpu <= '0; m_vec <= '0; m_ack <= 1'b0; m_err <= 1'b0; m_irq <= 1'b0;
    end else begin
      m_h1   <= irq_i;
      m_h2   <= m_h1;
      m_prev <= c_act;
      m_pend <= c_pend;
      if (c_wr && c_off == 3'd1) m_en   <= (m_en & ~c_wm) | c_wval;
      if (c_wr && c_off == 3'd2) m_mode <= (m_mode & ~c_wm) | c_wval;
      if (c_wr && c_off == 3'd3) m_pol  <= (m_pol & ~c_wm) | c_wval;
      m_ack <= c_acc & c_mapped;
      m_err <= c_acc & ~c_mapped;
      m_dat <= c_rd;
      m_cpu <= c_stat;
      m_irq <= |c_stat;
      m_vec <= c_vec;
    end
  end

  // Caller is 1ns after a rising edge; returns 1ns after the terminating edge with strobe dropped.
  task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         output logic [31:0] rdat, output logic ack, output logic err, output int waits);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    rdat = '0; ack = 1'b0; err = 1'b0; waits = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      waits++;
      if (wb_ack_o || wb_err_o) begin
        ack = wb_ack_o; err = wb_err_o; rdat = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d; logic a, e; int w;
    wb_xfer(1'b1, adr, dat, sel, d, a, e, w);
    @(posedge clk_i); #1;
  endtask

  task automatic rd(input logic [4:0] adr, output logic [31:0] d, output logic a);
    logic e; int w;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, d, a, e, w);
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic a, e; int w;
    nrst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if (irq_o !== 1'b0 || cpu_irq_o !== '0 || wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: irq=%b cpu=%h ack=%b err=%b dat=%h, required all 0",
               irq_o, cpu_irq_o, wb_ack_o, wb_err_o, wb_dat_o);
    end
    nrst_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wb_xfer(1'b0, 5'(i * 4), 32'h0, 4'hF, d, a, e, w);
      n_cmp++;
      if (d !== 32'h0 || a !== 1'b1 || e !== 1'b0 || w != 1) begin
        n_fail++;
        $display("FAIL reset_read_%0d: dat=%h ack=%b err=%b waits=%0d, required 0 ack 1 err 0 waits 1", i, d, a, e, w);
      end
      @(posedge clk_i); #1;
    end
    n_cmp++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: irq_o=%b, required 0", irq_o); end
    wb_adr_i = A_EN; wb_dat_i = 32'hFFFF_FFFF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; nrst_i = 1'b0;
    @(posedge clk_i); #1;
    n_cmp++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort: ack=%b err=%b, required 0 0", wb_ack_o, wb_err_o);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; nrst_i = 1'b1;
    @(posedge clk_i); #1;
    rd(A_EN, d, a);
    n_cmp++;
    if (d !== 32'h0 || !a) begin n_fail++; $display("FAIL reset_abort_nowrite: ENABLE=%h, required 0", d); end
  endtask

  task automatic test_level();
    logic [31:0] d; logic a;
    wr(A_EN, 32'h4, 4'hF);
    wr(A_MODE, 32'h0, 4'hF);
    irq_i[2] = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if (cpu_irq_o !== 32'h0) begin n_fail++; $display("FAIL level_latency_early: cpu=%h at E2, required 0", cpu_irq_o); end
    @(posedge clk_i); #1;
    n_cmp++;
    if (cpu_irq_o !== 32'h4 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL level_assert: cpu=%h irq=%b at E3, required 4 1", cpu_irq_o, irq_o);
    end
    wr(A_PEND, 32'h4, 4'hF);
    rd(A_PEND, d, a);
    n_cmp++;
    if (d !== 32'h4 || !a) begin n_fail++; $display("FAIL level_w1c_ignored: PENDING=%h, required 4", d); end
    irq_i[2] = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if (cpu_irq_o !== 32'h4) begin n_fail++; $display("FAIL level_drop_early: cpu=%h, required 4", cpu_irq_o); end
    @(posedge clk_i); #1;
    n_cmp++;
    if (cpu_irq_o !== 32'h0 || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL level_drop: cpu=%h irq=%b, required 0 0", cpu_irq_o, irq_o);
    end
  endtask

  task automatic test_edge();
    logic [31:0] d; logic a, e; int w;
    wr(A_MODE, 32'h1, 4'hF);
    wr(A_EN, 32'h1, 4'hF);
    irq_i[0] = 1'b1;
    @(posedge clk_i); #1;
    irq_i[0] = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rd(A_PEND, d, a);
    n_cmp++;
    if (d !== 32'h1 || !a) begin n_fail++; $display("FAIL edge_pending: PENDING=%h, required 1", d); end
    repeat (5) @(posedge clk_i);
    #1;
    rd(A_PEND, d, a);
    n_cmp++;
    if (d !== 32'h1 || cpu_irq_o !== 32'h1) begin
      n_fail++; $display("FAIL edge_sticky: PENDING=%h cpu=%h, required 1 1", d, cpu_irq_o);
    end
    wb_xfer(1'b1, A_PEND, 32'h1, 4'hF, d, a, e, w);
    n_cmp++;
    if (!a || cpu_irq_o !== 32'h1) begin n_fail++; $display("FAIL edge_w1c_ack: ack=%b cpu=%h, required 1 1", a, cpu_irq_o); end
    @(posedge clk_i); #1;
    n_cmp++;
    if (cpu_irq_o !== 32'h0) begin n_fail++; $display("FAIL edge_w1c_drop: cpu=%h, required 0", cpu_irq_o); end
    rd(A_PEND, d, a);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL edge_w1c_read: PENDING=%h, required 0", d); end
  endtask

  task automatic test_falling_collision();
    logic [31:0] d; logic a, e; int w;
    irq_i[1] = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    wr(A_POL, 32'h2, 4'hF);
    wr(A_MODE, 32'h2, 4'hF);
    rd(A_PEND, d, a);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL fall_idle: PENDING=%h, required 0", d); end
    irq_i[1] = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rd(A_PEND, d, a);
    n_cmp++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL fall_edge: PENDING=%h, required 2", d); end
    wr(A_MODE, 32'hA, 4'hF);
    irq_i[3] = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    wb_xfer(1'b1, A_PEND, 32'h8, 4'hF, d, a, e, w);
    @(posedge clk_i); #1;
    rd(A_PEND, d, a);
    n_cmp++;
    if (d !== 32'hA) begin n_fail++; $display("FAIL collision_set_wins: PENDING=%h, required a", d); end
    irq_i = '0;
    repeat (4) @(posedge clk_i);
    #1;
    wr(A_PEND, 32'hF, 4'hF);
    wr(A_SET, 32'h8, 4'hF);
    rd(A_PEND, d, a);
    n_cmp++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL set_edge: PENDING=%h, required 8", d); end
    rd(A_SET, d, a);
    n_cmp++;
    if (d !== 32'h0 || !a) begin n_fail++; $display("FAIL set_readback: SET=%h ack=%b, required 0 1", d, a); end
    wr(A_SET, 32'h1, 4'hF);
    rd(A_PEND, d, a);
    n_cmp++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL set_level_ignored: PENDING=%h, required 8", d); end
    wr(A_PEND, 32'h8, 4'hF);
    rd(A_PEND, d, a);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_after_set: PENDING=%h, required 0", d); end
  endtask

  task automatic test_byte_lanes_err();
    logic [31:0] d; logic a, e; int w;
    wr(A_EN, 32'h0, 4'hF);
    wr(A_EN, 32'hFFFF_FFFF, 4'h2);
    rd(A_EN, d, a);
    n_cmp++;
    if (d !== 32'h0000_FF00) begin n_fail++; $display("FAIL byte_lane: ENABLE=%h, required 0000ff00", d); end
    wb_xfer(1'b1, A_BAD, 32'hFFFF_FFFF, 4'hF, d, a, e, w);
    n_cmp++;
    if (e !== 1'b1 || a !== 1'b0 || d !== 32'h0 || w != 1) begin
      n_fail++; $display("FAIL err_write: err=%b ack=%b dat=%h waits=%0d, required 1 0 0 1", e, a, d, w);
    end
    @(posedge clk_i); #1;
    n_cmp++;
    if (wb_err_o !== 1'b0) begin n_fail++; $display("FAIL err_pulse: err=%b one cycle later, required 0", wb_err_o); end
    rd(A_EN, d, a);
    n_cmp++;
    if (d !== 32'h0000_FF00) begin n_fail++; $display("FAIL err_nochange_en: ENABLE=%h, required 0000ff00", d); end
    rd(A_MODE, d, a);
    n_cmp++;
    if (d !== 32'hA) begin n_fail++; $display("FAIL err_nochange_mode: MODE=%h, required a", d); end
    rd(A_POL, d, a);
    n_cmp++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL err_nochange_pol: POLARITY=%h, required 2", d); end
    wb_xfer(1'b0, A_BAD, 32'h0, 4'hF, d, a, e, w);
    n_cmp++;
    if (e !== 1'b1 || a !== 1'b0) begin n_fail++; $display("FAIL err_read: err=%b ack=%b, required 1 0", e, a); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_vector();
    logic [31:0] d; logic a, e; int w;
    wr(A_POL, 32'h0, 4'hF);
    wr(A_MODE, 32'h30, 4'hF);
    wr(A_EN, 32'h30, 4'hF);
    wr(A_SET, 32'h30, 4'hF);
    rd(A_STAT, d, a);
    n_cmp++;
    if (d !== 32'h30 || cpu_irq_o !== 32'h30 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL status: STATUS=%h cpu=%h irq=%b, required 30 30 1", d, cpu_irq_o, irq_o);
    end
`ifdef WB_INTC_VECTOR_EN
    rd(A_VEC, d, a);
    n_cmp++;
    if (d !== 32'h8000_0004 || !a) begin n_fail++; $display("FAIL vector: VECTOR=%h ack=%b, required 80000004 1", d, a); end
    wb_xfer(1'b1, A_VEC, 32'h0, 4'hF, d, a, e, w);
    n_cmp++;
    if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL vector_write: ack=%b err=%b, required 1 0", a, e); end
    @(posedge clk_i); #1;
    wr(A_PEND, 32'h10, 4'hF);
    rd(A_VEC, d, a);
    n_cmp++;
    if (d !== 32'h8000_0005) begin n_fail++; $display("FAIL vector_next: VECTOR=%h, required 80000005", d); end
`else
    wb_xfer(1'b0, A_VEC, 32'h0, 4'hF, d, a, e, w);
    n_cmp++;
    if (e !== 1'b1 || a !== 1'b0) begin n_fail++; $display("FAIL vector_unmapped: err=%b ack=%b, required 1 0", e, a); end
    @(posedge clk_i); #1;
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic a, e; int w;
    logic [3:0] acks;
    logic [31:0] dats [4];
    wr(A_EN, 32'h55, 4'hF);
    wb_xfer(1'b0, A_EN, 32'h0, 4'hF, d, a, e, w);
    wb_xfer(1'b0, A_EN, 32'h0, 4'hF, d, a, e, w);
    n_cmp++;
    if (w != 2 || d !== 32'h55 || !a) begin
      n_fail++; $display("FAIL b2b_second: waits=%0d dat=%h ack=%b, required 2 55 1", w, d, a);
    end
    @(posedge clk_i); #1;
    wb_adr_i = A_EN; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      acks[i] = wb_ack_o;
      dats[i] = wb_dat_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    n_cmp++;
    if (acks !== 4'b0101 || dats[0] !== 32'h55 || dats[1] !== 32'h0 || dats[2] !== 32'h55 || dats[3] !== 32'h0) begin
      n_fail++;
      $display("FAIL b2b_held: acks=%b dat=%h/%h/%h/%h, required 0101 55/0/55/0", acks, dats[0], dats[1], dats[2], dats[3]);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_random();
    nrst_i = 1'b0;
    irq_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    nrst_i = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) irq_i = $urandom;
      wb_cyc_i = 1'($urandom_range(0, 1));
      wb_stb_i = wb_cyc_i & ($urandom_range(0, 3) != 0);
      wb_adr_i = 5'($urandom);
      wb_we_i  = 1'($urandom_range(0, 1));
      wb_dat_i = $urandom;
      wb_sel_i = 4'($urandom);
      @(posedge clk_i); #1;
      n_cmp++;
      if (wb_ack_o !== m_ack || wb_err_o !== m_err) begin
        n_fail++; $display("FAIL rand_handshake cyc %0d: ack=%b err=%b, required %b %b", k, wb_ack_o, wb_err_o, m_ack, m_err);
      end
      n_cmp++;
      if (wb_dat_o !== m_dat) begin
        n_fail++; $display("FAIL rand_rdata cyc %0d: dat=%h, required %h", k, wb_dat_o, m_dat);
      end
      n_cmp++;
      if (cpu_irq_o !== m_cpu || irq_o !== m_irq) begin
        n_fail++; $display("FAIL rand_irq cyc %0d: cpu=%h irq=%b, required %h %b", k, cpu_irq_o, irq_o, m_cpu, m_irq);
      end
      n_cmp++;
      if (wb_rty_o !== 1'b0) begin n_fail++; $display("FAIL rand_rty cyc %0d: rty=%b, required 0", k, wb_rty_o); end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_level();
    test_edge();
    test_falling_collision();
    test_byte_lanes_err();
    test_vector();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
